// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector scan controller: FSM states,
// default parameters and the width helpers used to size the slot and index fields.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEF_W     = 20;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_Z_LAT = 1;

    // Number of 2-bit symbols in a W-bit word.
    function automatic int sym_count(input int w);
        return w / 2;
    endfunction

    function automatic int idx_width(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

    // The slot counter must reach N_SYM + Z_LAT - 1 without wrapping.
    function automatic int slot_width(input int w, input int z_lat);
        return $clog2(w / 2 + z_lat + 1);
    endfunction

endpackage

// File: rtl/seq_sym_shifter.sv
// W-bit load / shift-by-2 register presenting the word MSB-first as A/B symbols.
// The symbol outputs are registered and read zero on every cycle that is not a shift.
module seq_sym_shifter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] word_in,
    output logic         A,
    output logic         B
);

    logic [W-1:0] sr_q, sr_d;
    logic [1:0]   sym_q, sym_d;

    always_comb begin
        sr_d  = sr_q;
        sym_d = 2'b00;
        if (load) begin
            sr_d = word_in;
        end else if (shift) begin
            sym_d = sr_q[W-1 -: 2];
            sr_d  = {sr_q[W-3:0], 2'b00};
        end
    end

    // Word storage needs no reset: it is always reloaded before it is shifted out.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sym_q <= 2'b00;
        end else begin
            sym_q <= sym_d;
        end
    end

    assign A = sym_q[1];
    assign B = sym_q[0];

endmodule

// File: rtl/seq_scan_ctrl.sv
// Runs the 2-bit-per-cycle sequence detector from a parallel word: clears it,
// streams W/2 symbols, attributes each (latency-delayed) Z to its symbol and reports hits.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter  int W     = DEF_W,
    parameter  int CNT_W = DEF_CNT_W,
    parameter  int Z_LAT = DEF_Z_LAT,
    localparam int IDX_W = idx_width(W)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [W-1:0]     word_in,
    output logic             A,
    output logic             B,
    output logic             det_clr,
    input  logic             Z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_valid,
    output logic [IDX_W-1:0] first_hit_idx
);

    localparam int N_SYM  = sym_count(W);
    localparam int SLOT_W = slot_width(W, Z_LAT);

    localparam logic [SLOT_W-1:0] LAST_SYM_SLOT = SLOT_W'(N_SYM - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT     = SLOT_W'(N_SYM - 1 + Z_LAT);
    localparam logic [SLOT_W-1:0] LAT           = SLOT_W'(Z_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX       = '1;

    state_e state_q, state_d;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic              hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d;
    logic              det_clr_q, det_clr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              shift_en;
    logic              sampling;
    logic              attributed;
    logic [SLOT_W-1:0] sym_slot;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = CLEAR;
            CLEAR: state_d = SHIFT;
            SHIFT: if (slot_q == LAST_SYM_SLOT) state_d = (Z_LAT == 0) ? DONE : DRAIN;
            DRAIN: if (slot_q == LAST_SLOT) state_d = DONE;
            DONE:  state_d = start ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        accept    = start && (state_q == IDLE || state_q == DONE);
        shift_en  = (state_d == SHIFT);
        det_clr_d = (state_d == CLEAR);
        busy_d    = (state_d == CLEAR) || (state_d == SHIFT) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
    end

    always_comb begin
        sampling    = (state_q == SHIFT) || (state_q == DRAIN);
        sym_slot    = slot_q - LAT;
        attributed  = sampling && (slot_q >= LAT);
        slot_d      = sampling ? slot_q + 1'b1 : '0;
        hit_cnt_d   = hit_cnt_q;
        hit_valid_d = hit_valid_q;
        first_idx_d = first_idx_q;
        if (accept) begin
            hit_cnt_d   = '0;
            hit_valid_d = 1'b0;
            first_idx_d = '0;
        end else if (attributed && Z) begin
            if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
            if (!hit_valid_q) begin
                hit_valid_d = 1'b1;
                first_idx_d = sym_slot[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            slot_q      <= '0;
            hit_cnt_q   <= '0;
            hit_valid_q <= 1'b0;
            first_idx_q <= '0;
            det_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_valid_q <= hit_valid_d;
            first_idx_q <= first_idx_d;
            det_clr_q   <= det_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    seq_sym_shifter #(
        .W(W)
    ) u_shifter (
        .clk     (clk),
        .clr     (clr),
        .load    (accept),
        .shift   (shift_en),
        .word_in (word_in),
        .A       (A),
        .B       (B)
    );

    assign det_clr       = det_clr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign hit_cnt       = hit_cnt_q;
    assign hit_valid     = hit_valid_q;
    assign first_hit_idx = first_idx_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: two instances (CNT_W=4 and CNT_W=3) each driving a
// registered 2'b11 detector model; table, hand-written and random runs.
module tb_seq_scan_ctrl;

    localparam int W     = 20;
    localparam int N     = W / 2;
    localparam int Z_LAT = 1;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [W-1:0] word_in = '0;
    logic        z_force = 1'b0;

    logic       a0, b0, dc0, busy0, done0, hv0, z0;
    logic [3:0] cnt0, idx0;
    logic       a3, b3, dc3, busy3, done3, hv3, z3;
    logic [2:0] cnt3;
    logic [3:0] idx3;
    logic       zdet0 = 1'b0;
    logic       zdet3 = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Detector model: Z goes high the cycle after symbol 2'b11 is presented.
    always @(posedge clk) begin
        zdet0 <= a0 & b0;
        zdet3 <= a3 & b3;
    end
    assign z0 = zdet0 | z_force;
    assign z3 = zdet3 | z_force;

    seq_scan_ctrl #(.W(W), .CNT_W(4), .Z_LAT(Z_LAT)) dut (
        .clk(clk), .clr(clr), .start(start), .word_in(word_in),
        .A(a0), .B(b0), .det_clr(dc0), .Z(z0), .busy(busy0), .done(done0),
        .hit_cnt(cnt0), .hit_valid(hv0), .first_hit_idx(idx0)
    );

    seq_scan_ctrl #(.W(W), .CNT_W(3), .Z_LAT(Z_LAT)) dut3 (
        .clk(clk), .clr(clr), .start(start), .word_in(word_in),
        .A(a3), .B(b3), .det_clr(dc3), .Z(z3), .busy(busy3), .done(done3),
        .hit_cnt(cnt3), .hit_valid(hv3), .first_hit_idx(idx3)
    );

    typedef struct {
        logic [W-1:0] word;
        int           cnt;
        bit           valid;
        int           idx;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: count MSB-first symbols equal to 3 and note the first one.
    function automatic void ref_model(input logic [W-1:0] w, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int k = 0; k < N; k++) begin
            if (((w >> (W - 2 - 2 * k)) & 3) == 3) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
    endfunction

    function automatic int min7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    // Issues start with w; returns at the falling edge of the CLEAR cycle.
    task automatic launch(input logic [W-1:0] w);
        @(negedge clk);
        start = 1'b1;
        word_in = w;
        @(negedge clk);
        start = 1'b0;
        word_in = $urandom;
    endtask

    // Called at the falling edge of cycle 1 (CLEAR); returns at the falling edge of DONE.
    task automatic watch(input logic [W-1:0] w, input int inj, input int zf,
                         input int e_cnt, input bit e_val, input int e_idx, input string nm);
        int done_c = 0;
        int busy_n = 0;
        int ab;
        int exp_v;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            if (c == inj) begin start = 1'b1; word_in = ~w; end
            if (c == inj + 1) begin start = 1'b0; word_in = '0; end
            if (c == zf) z_force = 1'b1;
            if (c == zf + 2) z_force = 1'b0;
            ab = (c >= 2 && c <= N + 1) ? int'((w >> (W - 2 - 2 * (c - 2))) & 3) : 0;
            exp_v = (ab << 3) | ((c == 1) << 2) | ((c <= N + 1 + Z_LAT) << 1) | (c == N + 2 + Z_LAT);
            chk({nm, "/cyc"}, int'({a0, b0, dc0, busy0, done0}), exp_v);
            if (busy0) busy_n++;
            if (done0) begin
                done_c = c;
                break;
            end
        end
        chk({nm, "/done_cycle"}, done_c, N + 2 + Z_LAT);
        chk({nm, "/busy_cycles"}, busy_n, N + 1 + Z_LAT);
        chk({nm, "/hit_cnt"}, int'(cnt0), e_cnt);
        chk({nm, "/hit_valid"}, int'(hv0), int'(e_val));
        chk({nm, "/first_idx"}, int'(idx0), e_idx);
        chk({nm, "/hit_cnt3"}, int'(cnt3), min7(e_cnt));
        chk({nm, "/first_idx3"}, int'(idx3), e_idx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int rf;
        logic [W-1:0] rw;

        vecs[0] = '{20'h73BDC, 5, 1'b1, 1};
        vecs[1] = '{20'h00000, 0, 1'b0, 0};
        vecs[2] = '{20'hFFFFF, 10, 1'b1, 0};
        vecs[3] = '{20'h00003, 1, 1'b1, 9};
        vecs[4] = '{20'hC0000, 1, 1'b1, 0};
        vecs[5] = '{20'h33333, 5, 1'b1, 1};
        vecs[6] = '{20'hAAAAA, 0, 1'b0, 0};

        repeat (2) @(negedge clk);
        chk("reset/outs", int'({a0, b0, dc0, busy0, done0, cnt0, hv0, idx0}), 0);
        chk("reset/outs3", int'({a3, b3, dc3, busy3, done3, cnt3, hv3, idx3}), 0);
        clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i].word);
            watch(vecs[i].word, 0, 0, vecs[i].cnt, vecs[i].valid, vecs[i].idx, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d/hold_cnt", i), int'(cnt0), vecs[i].cnt);
            chk($sformatf("vec%0d/idle", i), int'({busy0, done0, dc0}), 0);
        end

        // start mid-SHIFT is ignored; start held in DONE chains straight into CLEAR
        launch(20'h73BDC);
        watch(20'h73BDC, 5, 0, 5, 1'b1, 1, "s4a");
        start = 1'b1;
        word_in = 20'h00003;
        @(negedge clk);
        start = 1'b0;
        word_in = '0;
        watch(20'h00003, 0, 0, 1, 1'b1, 9, "s4b");

        // asynchronous abort at symbol 4
        launch(20'h73BDC);
        repeat (5) @(negedge clk);
        chk("s5/pre_busy", int'(busy0), 1);
        clr = 1'b1;
        #1;
        chk("s5/abort", int'({a0, b0, dc0, busy0, done0, cnt0, hv0, idx0}), 0);
        chk("s5/abort3", int'({a3, b3, dc3, busy3, done3, cnt3, hv3, idx3}), 0);
        @(negedge clk);
        clr = 1'b0;
        launch(20'h73BDC);
        watch(20'h73BDC, 0, 0, 5, 1'b1, 1, "s5");

        // Z forced through CLEAR and slot 0, then across DONE and the idle cycle after
        launch(20'h00000);
        watch(20'h00000, 0, 1, 0, 1'b0, 0, "s6");
        z_force = 1'b1;
        repeat (2) @(negedge clk);
        z_force = 1'b0;
        chk("s6/after_cnt", int'(cnt0), 0);
        chk("s6/after_valid", int'(hv0), 0);

        for (int i = 0; i < 12; i++) begin
            rw = W'($urandom);
            if (i % 3 == 0) rw = rw | W'($urandom) | W'($urandom);
            ref_model(rw, rc, rf);
            launch(rw);
            watch(rw, 0, 0, rc, rc > 0, rf, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
